// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the data-memory access unit: load/store op
// encoding, access-size classification, alignment check and FSM states.
package mem_access_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic size_e op_size(input logic [2:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            OP_LW, OP_SW:         return SZ_WORD;
            default:              return SZ_BYTE;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op_size(op))
            SZ_HALF: return a[0];
            SZ_WORD: return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align
// Picks the addressed byte/half/word out of a memory read word and
// sign- or zero-extends it according to the load op.
//   mem_rdata_i : raw 32-bit word from memory
//   addr_i      : byte offset within the word
//   op_i        : load op code
//   ext_data_o  : aligned, extended load result
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  op_i,
    output logic [31:0] ext_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_rdata_i[{addr_i, 3'b000} +: 8];
    assign half_sel = mem_rdata_i[{addr_i[1], 4'b0000} +: 16];

    always_comb begin
        case (op_i)
            OP_LB:   ext_data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ext_data_o = {24'b0, byte_sel};
            OP_LH:   ext_data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext_data_o = {16'b0, half_sel};
            default: ext_data_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Initiator side of the data-memory port. Takes one load/store at a time
// over a valid/ready handshake, holds address/data on the memory port for
// WAIT_CYCLES+1 cycles, then reports an extended load result or an
// alignment error as a one-cycle response pulse.
//   clk, rst          : clock, asynchronous active-high reset
//   req_*             : CPU request (valid/ready, op, byte address, store data)
//   resp_*            : one-cycle response pulse, result and error flag
//   mem_addr/wdata/wen: word address, lane-placed store data, lane enables
//   mem_rdata         : asynchronous read data for mem_addr
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wen,
    input  logic [31:0] mem_rdata
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [3:0]         lane_wen;
    logic [31:0]        lane_wdata;
    logic [31:0]        load_data;

    mem_load_align u_load_align (
        .mem_rdata_i (mem_rdata),
        .addr_i      (addr_q[1:0]),
        .op_i        (op_q),
        .ext_data_o  (load_data)
    );

    // Lane placement is derived from the latched request only, so the
    // memory port stays stable for the whole ACCESS state.
    always_comb begin
        lane_wen   = 4'b0000;
        lane_wdata = 32'b0;
        case (op_q)
            OP_SB: begin
                lane_wen   = 4'b0001 << addr_q[1:0];
                lane_wdata = {24'b0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
            end
            OP_SH: begin
                lane_wen   = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = addr_q[1] ? {wdata_q[15:0], 16'b0} : {16'b0, wdata_q[15:0]};
            end
            OP_SW: begin
                lane_wen   = 4'b1111;
                lane_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    assign mem_addr   = {2'b00, addr_q[31:2]};
    assign mem_wdata  = lane_wdata;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'b000;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Result/error registers change only when entering RESP so they hold
    // their last value between responses.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wen    = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (misaligned(req_op, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        rdata_d = 32'b0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (is_store(op_q)) begin
                        mem_wen = lane_wen;
                        rdata_d = 32'b0;
                    end else begin
                        rdata_d = load_data;
                    end
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Two instances: WAIT_CYCLES=0 (index 0) and WAIT_CYCLES=3 (index 1).
// Directed vector table plus hand sequences for back-to-back requests and
// reset in the middle of an access.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_wen;
        logic [31:0] exp_wdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [2:0]  req_op     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_wdata  [2];
    logic [3:0]  mem_wen    [2];
    logic [31:0] mem_rdata  [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wen(mem_wen[0]),
        .mem_rdata(mem_rdata[0])
    );

    mem_access_unit #(.WAIT_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wen(mem_wen[1]),
        .mem_rdata(mem_rdata[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mrd,
                                input logic err, input logic [31:0] rdata,
                                input logic [3:0] wen, input logic [31:0] wd);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.mrd = mrd;
        v.exp_err = err; v.exp_rdata = rdata; v.exp_wen = wen; v.exp_wdata = wd;
        return v;
    endfunction

    task automatic run_vec(input int d, input vec_t v, input string tag);
        int          wc;
        int          exp_cyc;
        int          wen_cnt = 0;
        int          wen_cyc = 0;
        int          resp_cnt = 0;
        int          resp_cyc = 0;
        int          rdy_hi = 0;
        logic [3:0]  wen_v = 4'b0;
        logic [31:0] wd_v = 32'b0;
        logic [31:0] ma_v = 32'b0;
        logic [31:0] rd_v = 32'b0;
        logic        er_v = 1'b0;
        logic        st;
        wc      = (d == 0) ? 0 : 3;
        st      = is_store(v.op);
        exp_cyc = v.exp_err ? 1 : wc + 2;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_op[d]    = v.op;
        req_addr[d]  = v.addr;
        req_wdata[d] = v.wdata;
        mem_rdata[d] = v.mrd;
        check($sformatf("%s_ready_idle", tag), 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_op[d]    = 3'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        for (int c = 1; c <= wc + 3; c++) begin
            @(negedge clk);
            if (mem_wen[d] != 4'b0) begin
                wen_cnt++;
                wen_cyc = c;
                wen_v   = mem_wen[d];
                wd_v    = mem_wdata[d];
            end
            if (c == 1) ma_v = mem_addr[d];
            if (resp_valid[d]) begin
                resp_cnt++;
                resp_cyc = c;
                rd_v     = resp_rdata[d];
                er_v     = resp_err[d];
            end
            if (c <= exp_cyc && req_ready[d]) rdy_hi++;
        end
        check($sformatf("%s_resp_count", tag), 32'(resp_cnt), 32'd1);
        check($sformatf("%s_resp_cycle", tag), 32'(resp_cyc), 32'(exp_cyc));
        check($sformatf("%s_rdata", tag), rd_v, v.exp_rdata);
        check($sformatf("%s_err", tag), 32'(er_v), 32'(v.exp_err));
        check($sformatf("%s_wen_count", tag), 32'(wen_cnt), (st && !v.exp_err) ? 32'd1 : 32'd0);
        check($sformatf("%s_ready_low_busy", tag), 32'(rdy_hi), 32'd0);
        check($sformatf("%s_rdata_hold", tag), resp_rdata[d], v.exp_rdata);
        check($sformatf("%s_ready_back", tag), 32'(req_ready[d]), 32'd1);
        if (!v.exp_err)
            check($sformatf("%s_mem_addr", tag), ma_v, v.addr >> 2);
        if (st && !v.exp_err) begin
            check($sformatf("%s_wen", tag), 32'(wen_v), 32'(v.exp_wen));
            check($sformatf("%s_wdata", tag), wd_v, v.exp_wdata);
            check($sformatf("%s_wen_cycle", tag), 32'(wen_cyc), 32'(wc + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs [15];
        logic [11:0] rdy_pat;
        logic [11:0] resp_pat;
        logic [11:0] wen_pat;
        logic [31:0] rd2;
        int          bad_wen;
        int          bad_resp;
        int          bad_rdy;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_op[d]    = 3'b000;
            req_addr[d]  = 32'b0;
            req_wdata[d] = 32'b0;
            mem_rdata[d] = 32'b0;
        end

        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d_ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("rst%0d_resp_valid", d), 32'(resp_valid[d]), 32'd0);
            check($sformatf("rst%0d_resp_rdata", d), resp_rdata[d], 32'd0);
            check($sformatf("rst%0d_resp_err", d), 32'(resp_err[d]), 32'd0);
            check($sformatf("rst%0d_mem_addr", d), mem_addr[d], 32'd0);
            check($sformatf("rst%0d_mem_wdata", d), mem_wdata[d], 32'd0);
            check($sformatf("rst%0d_mem_wen", d), 32'(mem_wen[d]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        //              op      addr          wdata          mem_rdata     err   rdata          wen      wdata
        vecs[0]  = mk(OP_SW,  32'h0000_0010, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0,         4'b1111, 32'hDEADBEEF);
        vecs[1]  = mk(OP_SB,  32'h0000_0013, 32'h0000_00A5, 32'h0,       1'b0, 32'h0,         4'b1000, 32'hA500_0000);
        vecs[2]  = mk(OP_LB,  32'h0000_0013, 32'h0,        32'hA500_0000, 1'b0, 32'hFFFF_FFA5, 4'b0000, 32'h0);
        vecs[3]  = mk(OP_LBU, 32'h0000_0013, 32'h0,        32'hA500_0000, 1'b0, 32'h0000_00A5, 4'b0000, 32'h0);
        vecs[4]  = mk(OP_LH,  32'h0000_0022, 32'h0,        32'h8001_1234, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0);
        vecs[5]  = mk(OP_LHU, 32'h0000_0022, 32'h0,        32'h8001_1234, 1'b0, 32'h0000_8001, 4'b0000, 32'h0);
        vecs[6]  = mk(OP_SH,  32'h0000_0022, 32'h1234_5678, 32'h0,       1'b0, 32'h0,         4'b1100, 32'h5678_0000);
        vecs[7]  = mk(OP_LW,  32'h0000_0006, 32'h0,        32'hFFFF_FFFF, 1'b1, 32'h0,         4'b0000, 32'h0);
        vecs[8]  = mk(OP_LW,  32'h0000_000C, 32'h0,        32'h1234_5678, 1'b0, 32'h1234_5678, 4'b0000, 32'h0);
        vecs[9]  = mk(OP_SH,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0,       1'b1, 32'h0,         4'b0000, 32'h0);
        vecs[10] = mk(OP_LB,  32'h0000_0001, 32'h0,        32'h0000_7F00, 1'b0, 32'h0000_007F, 4'b0000, 32'h0);
        vecs[11] = mk(OP_SB,  32'h0000_0000, 32'hFFFF_FF3C, 32'h0,       1'b0, 32'h0,         4'b0001, 32'h0000_003C);
        vecs[12] = mk(OP_LH,  32'h0000_0020, 32'h0,        32'h1234_ABCD, 1'b0, 32'hFFFF_ABCD, 4'b0000, 32'h0);
        vecs[13] = mk(OP_LHU, 32'h0000_0020, 32'h0,        32'h1234_ABCD, 1'b0, 32'h0000_ABCD, 4'b0000, 32'h0);
        vecs[14] = mk(OP_SH,  32'h0000_0004, 32'h0000_BEEF, 32'h0,       1'b0, 32'h0,         4'b0011, 32'h0000_BEEF);

        for (int i = 0; i < 15; i++)
            run_vec(0, vecs[i], $sformatf("w0_v%0d", i));

        run_vec(1, mk(OP_SW, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF), "w3_sw");
        run_vec(1, mk(OP_LH, 32'h0000_0003, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0), "w3_lh_misal");
        run_vec(1, mk(OP_LBU, 32'h0000_0012, 32'h0, 32'h00C3_0000, 1'b0, 32'h0000_00C3, 4'b0000, 32'h0), "w3_lbu");

        // Back-to-back: second request held valid during the first access.
        rdy_pat  = '0;
        resp_pat = '0;
        wen_pat  = '0;
        rd2      = 32'b0;
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_op[1]    = OP_SW;
        req_addr[1]  = 32'h0000_0040;
        req_wdata[1] = 32'h1122_3344;
        mem_rdata[1] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req_op[1]    = OP_LW;
        req_addr[1]  = 32'h0000_0044;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            rdy_pat[c-1]  = req_ready[1];
            resp_pat[c-1] = resp_valid[1];
            wen_pat[c-1]  = (mem_wen[1] != 4'b0);
            if (c == 11) rd2 = resp_rdata[1];
            if (c == 7) req_valid[1] = 1'b0;
        end
        check("b2b_ready_pattern", 32'(rdy_pat), 32'h820);
        check("b2b_resp_pattern", 32'(resp_pat), 32'h410);
        check("b2b_wen_pattern", 32'(wen_pat), 32'h008);
        check("b2b_second_rdata", rd2, 32'hCAFE_F00D);

        // Reset while the store strobe is active: strobe must vanish at once.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_op[1]    = OP_SW;
        req_addr[1]  = 32'h0000_0050;
        req_wdata[1] = 32'h0000_0099;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_pre_ready", 32'(req_ready[1]), 32'd0);
        check("rstmid_pre_wen", 32'(mem_wen[1]), 32'hF);
        rst = 1'b1;
        #1;
        check("rstmid_wen", 32'(mem_wen[1]), 32'd0);
        check("rstmid_resp_valid", 32'(resp_valid[1]), 32'd0);
        check("rstmid_ready", 32'(req_ready[1]), 32'd1);
        check("rstmid_mem_addr", mem_addr[1], 32'd0);
        bad_wen  = 0;
        bad_resp = 0;
        bad_rdy  = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_wen[1] != 4'b0) bad_wen++;
            if (resp_valid[1]) bad_resp++;
            if (!req_ready[1]) bad_rdy++;
        end
        check("rstmid_no_wen_after", 32'(bad_wen), 32'd0);
        check("rstmid_no_resp_after", 32'(bad_resp), 32'd0);
        check("rstmid_ready_after", 32'(bad_rdy), 32'd0);
        check("rstmid_rdata_cleared", resp_rdata[1], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port.
- Accepts one load/store request at a time from the CPU datapath via a valid/ready handshake.
- Drives word address, byte-lane write enables and lane-aligned write data to the data memory, then returns an aligned, sign- or zero-extended load result or an alignment error.
- Supports a configurable number of memory wait cycles so the same unit can front slower memories.

Parameters:
WAIT_CYCLES, 0, extra cycles the memory port is held before write commit / read capture (0..15)
CNT_W, 4, width of the wait counter; must hold WAIT_CYCLES

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  CPU request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_op  input  3  operation code (see package)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle pulse: result/error available
resp_rdata  output  32  extended load result; 0 for stores and errors
resp_err  output  1  misaligned access; valid with resp_valid
mem_addr  output  32  word address = latched req_addr >> 2
mem_wdata  output  32  store data shifted into its byte lane(s)
mem_wen  output  4  byte-lane write enables; memory writes on rising clk
mem_rdata  input  32  asynchronous read data for mem_addr

Behaviour:
- Reset is asynchronous: state=IDLE, counter=0, latched op/addr/wdata=0. All outputs 0 except req_ready=1. Reset mid-ACCESS drops mem_wen immediately, so no partial write commits.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready at a rising edge, latch op, addr and wdata.
  - If misaligned, go to RESP with err flag set and never enter ACCESS (mem_wen stays 0). Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Otherwise go to ACCESS with counter=WAIT_CYCLES.
- ACCESS:
  - req_ready=0.
  - mem_addr and mem_wdata are held stable for the whole state.
  - Counter decrements each cycle while non-zero.
  - In the cycle with counter==0:
    - Store: mem_wen is asserted for exactly that cycle.
    - Load: mem_rdata is captured, aligned and extended into the result register.
  - Next state is RESP.
  - mem_wen=0 in every other cycle and state.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err; next state IDLE. No response backpressure; the CPU must sample the pulse.
- Latency:
  - resp_valid is high in the (WAIT_CYCLES+2)th cycle after the accept edge.
  - Misaligned error responds in the 1st cycle after accept.
  - Throughput is one request per WAIT_CYCLES+3 cycles; req_ready is low in ACCESS and RESP.
- Store lane placement (o = addr[1:0]):
  - SB: mem_wen = 4'b0001<<o, mem_wdata = wdata[7:0]<<(8*o).
  - SH: mem_wen = 4'b0011<<(2*addr[1]), mem_wdata = wdata[15:0]<<(16*addr[1]).
  - SW: mem_wen = 4'b1111, mem_wdata = wdata.
  - Unused lanes are 0.
- Load extraction:
  - Byte = mem_rdata[8*o +: 8]; LB sign-extends from bit 7, LBU zero-extends.
  - Half = mem_rdata[16*addr[1] +: 16]; LH sign-extends from bit 15, LHU zero-extends.
  - LW returns mem_rdata.
- req_valid while not ready is ignored; the CPU holds the request. Request inputs are don't-care after the accept edge.
- resp_rdata/resp_err hold their last values after resp_valid falls, until the next response.

Decomposition:
- Package mem_access_pkg holds the op encoding: LB=3'b000, LH=001, LW=010, LBU=011, LHU=100, SB=101, SH=110, SW=111. It also holds an is_store/size helper function and the FSM state enum.
- One natural combinational sub-module, mem_load_align: inputs mem_rdata, addr[1:0] and op; output is the 32-bit extended result.
- Store lane shifting stays inline.

Test Plan:
- SW addr=0x0000_0010 wdata=0xDEADBEEF, WAIT_CYCLES=0 -> mem_addr=0x4, mem_wen=4'b1111 for exactly 1 cycle; resp_valid in 2nd cycle after accept, resp_rdata=0, resp_err=0.
- SB addr=0x13 wdata=0x000000A5 -> mem_wen=4'b1000, mem_wdata=0xA5000000. Then LB addr=0x13 with mem_rdata=0xA5000000 -> resp_rdata=0xFFFFFFA5; LBU same address -> 0x000000A5.
- LH addr=0x22 with mem_rdata=0x8001_1234 -> resp_rdata=0xFFFF8001; LHU -> 0x00008001; SH addr=0x22 wdata=0x5678 -> mem_wen=4'b1100, mem_wdata=0x56780000.
- LW addr=0x06 -> resp_err=1 in 1st cycle after accept, resp_rdata=0, mem_wen never asserted. SH addr=0x01 -> same error behaviour.
- WAIT_CYCLES=3, SW -> mem_wen high only in the 4th ACCESS cycle; resp_valid in the 5th cycle after accept. req_ready=0 throughout; a second req_valid held is accepted only on return to IDLE.
- Assert rst during ACCESS of an SW with WAIT_CYCLES=3 -> mem_wen and resp_valid drop immediately, req_ready=1; no write pulse occurs.
